// File: rtl/cp0_pkg.sv
// cp0_pkg
// Shared definitions for the CP0 exception path: exception codes, the
// exception scheduler FSM state type and the grant vector layout used by
// the slot priority encoder.
// No ports (package).
package cp0_pkg;

  localparam logic [4:0] EXC_INT    = 5'h00;
  localparam logic [4:0] EXC_HLT    = 5'h01;
  localparam logic [4:0] EXC_RESUME = 5'h02;
  localparam logic [4:0] EXC_ADEL   = 5'h04;
  localparam logic [4:0] EXC_ADES   = 5'h05;
  localparam logic [4:0] EXC_SYS    = 5'h08;
  localparam logic [4:0] EXC_BP     = 5'h09;
  localparam logic [4:0] EXC_RI     = 5'h0a;
  localparam logic [4:0] EXC_OF     = 5'h0c;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_TAKE  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } sched_state_t;

  // Grant bits 0..2 select pipeline slots ID/EX/MEM; the two above them
  // select an interrupt and an ERET.
  localparam int GNT_W    = 5;
  localparam int GNT_INT  = 3;
  localparam int GNT_ERET = 4;

endpackage

// File: rtl/ex_prio_enc.sv
// ex_prio_enc
// Combinational one-hot priority selection among pending exception sources.
// Ports:
//   req_valid  in  per-slot exception request (bit2 = MEM, oldest)
//   int_pend   in  interrupt pending and attachable to the MEM instruction
//   eret_req   in  ERET present in MEM
//   grant      out one-hot winner, layout given by cp0_pkg GNT_* constants
module ex_prio_enc
  import cp0_pkg::*;
(
  input  logic [2:0]       req_valid,
  input  logic             int_pend,
  input  logic             eret_req,
  output logic [GNT_W-1:0] grant
);

  // Oldest instruction first; interrupts only after all synchronous
  // exceptions, and an ERET only when nothing else wants the pipe.
  always_comb begin
    grant = '0;
    if (req_valid[2])      grant[2]        = 1'b1;
    else if (req_valid[1]) grant[1]        = 1'b1;
    else if (req_valid[0]) grant[0]        = 1'b1;
    else if (int_pend)     grant[GNT_INT]  = 1'b1;
    else if (eret_req)     grant[GNT_ERET] = 1'b1;
  end

endmodule

// File: rtl/ex_sched.sv
// ex_sched
// Exception scheduler: picks the winning exception/interrupt/ERET while the
// pipe is running, emits a one-cycle commit pulse to CP0, flushes and stalls
// the pipeline, and manages the halt/resume sequence.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   req_valid/code/pc/bd        per-slot exception requests (slot 2 = MEM)
//   mem_inst_valid              real instruction in MEM (interrupt anchor)
//   eret_req                    ERET present in MEM
//   ie_in, exl_in               STATUS.IE / STATUS.EXL
//   int_mask_in, int_sig_in     STATUS.IM / CAUSE.IP
//   hlt_in                      CP0 halt flag
//   ex_wb, ex_code, epc,        exception commit pulse with its code,
//   branch_delay_wb             raw faulting PC and branch-delay flag
//   eret_flush                  ERET commit pulse
//   pipe_flush, pipe_stall      pipeline control
module ex_sched
  import cp0_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int EX_CODE_W    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             req_valid,
  input  logic [3*EX_CODE_W-1:0] req_code,
  input  logic [95:0]            req_pc,
  input  logic [2:0]             req_bd,
  input  logic                   mem_inst_valid,
  input  logic                   eret_req,
  input  logic                   ie_in,
  input  logic                   exl_in,
  input  logic [7:0]             int_mask_in,
  input  logic [7:0]             int_sig_in,
  input  logic                   hlt_in,
  output logic                   ex_wb,
  output logic [EX_CODE_W-1:0]   ex_code,
  output logic [31:0]            epc,
  output logic                   branch_delay_wb,
  output logic                   eret_flush,
  output logic                   pipe_flush,
  output logic                   pipe_stall
);

  // The cycle that starts the flush counts as the first flush cycle.
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  sched_state_t           state;
  logic [2:0]             flush_cnt;
  logic                   halt_pend;
  logic                   hlt_low;
  logic                   int_pend;
  logic [GNT_W-1:0]       grant;
  logic                   take_exc;
  logic [EX_CODE_W-1:0]   sel_code;
  logic [31:0]            sel_pc;
  logic                   sel_bd;

  assign int_pend = ie_in & ~exl_in & (|(int_sig_in & int_mask_in));
  assign take_exc = |grant[GNT_INT:0];

  ex_prio_enc u_prio (
    .req_valid (req_valid),
    .int_pend  (int_pend & mem_inst_valid),
    .eret_req  (eret_req),
    .grant     (grant)
  );

  // An interrupt reports the PC and delay-slot flag of the MEM instruction
  // it is attached to.
  always_comb begin
    sel_code = '0;
    sel_pc   = '0;
    sel_bd   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (grant[k]) begin
        sel_code = req_code[k*EX_CODE_W +: EX_CODE_W];
        sel_pc   = req_pc[k*32 +: 32];
        sel_bd   = req_bd[k];
      end
    end
    if (grant[GNT_INT]) begin
      sel_code = EX_CODE_W'(EXC_INT);
      sel_pc   = req_pc[95:64];
      sel_bd   = req_bd[2];
    end
  end

  // Requests are only looked at in RUN; anything arriving during TAKE or
  // FLUSH belongs to instructions being flushed and is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_RUN;
      flush_cnt       <= '0;
      halt_pend       <= 1'b0;
      hlt_low         <= 1'b0;
      ex_wb           <= 1'b0;
      ex_code         <= '0;
      epc             <= '0;
      branch_delay_wb <= 1'b0;
      eret_flush      <= 1'b0;
      pipe_flush      <= 1'b0;
      pipe_stall      <= 1'b0;
    end else begin
      ex_wb           <= 1'b0;
      ex_code         <= '0;
      epc             <= '0;
      branch_delay_wb <= 1'b0;
      eret_flush      <= 1'b0;
      case (state)
        ST_RUN: begin
          if (take_exc) begin
            state           <= ST_TAKE;
            ex_wb           <= 1'b1;
            ex_code         <= sel_code;
            epc             <= sel_pc;
            branch_delay_wb <= sel_bd;
            pipe_flush      <= 1'b1;
            pipe_stall      <= 1'b1;
            flush_cnt       <= FLUSH_INIT;
            halt_pend       <= (sel_code == EX_CODE_W'(EXC_HLT));
          end else if (grant[GNT_ERET]) begin
            state      <= ST_FLUSH;
            eret_flush <= 1'b1;
            pipe_flush <= 1'b1;
            pipe_stall <= 1'b1;
            flush_cnt  <= FLUSH_INIT;
            halt_pend  <= 1'b0;
          end
        end
        ST_TAKE, ST_FLUSH: begin
          if (flush_cnt != 3'd0) begin
            state     <= ST_FLUSH;
            flush_cnt <= flush_cnt - 3'd1;
          end else begin
            pipe_flush <= 1'b0;
            halt_pend  <= 1'b0;
            hlt_low    <= 1'b0;
            if (halt_pend) begin
              state <= ST_HALT;
            end else begin
              state      <= ST_RUN;
              pipe_stall <= 1'b0;
            end
          end
        end
        ST_HALT: begin
          // Resume reports epc/bd as zero, which the defaults above supply.
          if (int_pend) begin
            state      <= ST_TAKE;
            ex_wb      <= 1'b1;
            ex_code    <= EX_CODE_W'(EXC_RESUME);
            pipe_flush <= 1'b1;
            flush_cnt  <= FLUSH_INIT;
          end else if (!hlt_in && hlt_low) begin
            state      <= ST_RUN;
            pipe_stall <= 1'b0;
          end else begin
            hlt_low <= !hlt_in;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_sched.sv
// tb_ex_sched
// Self-checking bench for ex_sched. Two instances (FLUSH_CYCLES 2 and 3)
// share the same stimulus; a cycle-level model derived from the scheduling
// rules predicts every output of both, and directed scenarios add literal
// expectations.
module tb_ex_sched;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_code;
  logic [95:0] req_pc;
  logic [2:0]  req_bd;
  logic        mem_inst_valid;
  logic        eret_req;
  logic        ie_in;
  logic        exl_in;
  logic [7:0]  int_mask_in;
  logic [7:0]  int_sig_in;
  logic        hlt_in;

  logic        a_wb, a_bd, a_eret, a_flush, a_stall;
  logic [4:0]  a_code;
  logic [31:0] a_epc;
  logic        b_wb, b_bd, b_eret, b_flush, b_stall;
  logic [4:0]  b_code;
  logic [31:0] b_epc;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  // Model state per instance: index 0 = FLUSH_CYCLES 2, index 1 = 3.
  int   m_flush_to[2] = '{-1000, -1000};
  bit   m_halted[2]   = '{1'b0, 1'b0};
  bit   m_pend[2]     = '{1'b0, 1'b0};
  bit   m_low[2]      = '{1'b0, 1'b0};
  logic m_wb[2], m_bd[2], m_eret[2], m_flush[2], m_stall[2];
  logic [4:0]  m_code[2];
  logic [31:0] m_epc[2];

  ex_sched #(.FLUSH_CYCLES(2), .EX_CODE_W(5)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_code(req_code),
    .req_pc(req_pc), .req_bd(req_bd), .mem_inst_valid(mem_inst_valid),
    .eret_req(eret_req), .ie_in(ie_in), .exl_in(exl_in),
    .int_mask_in(int_mask_in), .int_sig_in(int_sig_in), .hlt_in(hlt_in),
    .ex_wb(a_wb), .ex_code(a_code), .epc(a_epc), .branch_delay_wb(a_bd),
    .eret_flush(a_eret), .pipe_flush(a_flush), .pipe_stall(a_stall)
  );

  ex_sched #(.FLUSH_CYCLES(3), .EX_CODE_W(5)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_code(req_code),
    .req_pc(req_pc), .req_bd(req_bd), .mem_inst_valid(mem_inst_valid),
    .eret_req(eret_req), .ie_in(ie_in), .exl_in(exl_in),
    .int_mask_in(int_mask_in), .int_sig_in(int_sig_in), .hlt_in(hlt_in),
    .ex_wb(b_wb), .ex_code(b_code), .epc(b_epc), .branch_delay_wb(b_bd),
    .eret_flush(b_eret), .pipe_flush(b_flush), .pipe_stall(b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model step for one edge. Interval e is the time right after edge e;
  // a winner taken at edge e flushes intervals e .. e+F-1, so the next
  // sample happens at the first edge whose preceding interval is free.
  task automatic model_step(input int i);
    int   e;
    int   f;
    int   win;
    logic ip;
    e = edge_cnt;
    f = (i == 0) ? 2 : 3;
    m_wb[i] = 1'b0; m_code[i] = 5'h0; m_epc[i] = 32'h0; m_bd[i] = 1'b0; m_eret[i] = 1'b0;
    if (!rst) begin
      m_flush_to[i] = -1000; m_halted[i] = 1'b0; m_pend[i] = 1'b0; m_low[i] = 1'b0;
      m_flush[i] = 1'b0; m_stall[i] = 1'b0;
      return;
    end
    ip = ie_in && !exl_in && ((int_sig_in & int_mask_in) != 8'h00);
    if (e - 1 >= m_flush_to[i]) begin
      if (m_pend[i]) begin
        m_halted[i] = 1'b1; m_pend[i] = 1'b0; m_low[i] = 1'b0;
      end
      if (m_halted[i]) begin
        if (ip) begin
          m_wb[i] = 1'b1; m_code[i] = 5'h02; m_flush_to[i] = e + f; m_halted[i] = 1'b0;
        end else if (!hlt_in && m_low[i]) begin
          m_halted[i] = 1'b0;
        end else begin
          m_low[i] = !hlt_in;
        end
      end else begin
        win = -1;
        for (int k = 2; k >= 0; k--) if (win < 0 && req_valid[k]) win = k;
        if (win >= 0) begin
          m_wb[i] = 1'b1; m_code[i] = req_code[5*win +: 5];
          m_epc[i] = req_pc[32*win +: 32]; m_bd[i] = req_bd[win];
        end else if (ip && mem_inst_valid) begin
          m_wb[i] = 1'b1; m_code[i] = 5'h00; m_epc[i] = req_pc[95:64]; m_bd[i] = req_bd[2];
        end
        if (m_wb[i]) begin
          m_flush_to[i] = e + f; m_pend[i] = (m_code[i] == 5'h01);
        end else if (eret_req) begin
          m_eret[i] = 1'b1; m_flush_to[i] = e + f;
        end
      end
    end
    m_flush[i] = (e < m_flush_to[i]);
    m_stall[i] = m_flush[i] || m_halted[i] || m_pend[i];
  endtask

  task automatic checkDut(input int i, input logic wb, input logic [4:0] code,
                          input logic [31:0] pc, input logic bd, input logic er,
                          input logic fl, input logic st);
    string p;
    p = (i == 0) ? "A" : "B";
    checkOutput({p, ".ex_wb"},           32'(wb),   32'(m_wb[i]));
    checkOutput({p, ".ex_code"},         32'(code), 32'(m_code[i]));
    checkOutput({p, ".epc"},             pc,        m_epc[i]);
    checkOutput({p, ".branch_delay_wb"}, 32'(bd),   32'(m_bd[i]));
    checkOutput({p, ".eret_flush"},      32'(er),   32'(m_eret[i]));
    checkOutput({p, ".pipe_flush"},      32'(fl),   32'(m_flush[i]));
    checkOutput({p, ".pipe_stall"},      32'(st),   32'(m_stall[i]));
  endtask

  always @(posedge clk) begin
    edge_cnt = edge_cnt + 1;
    model_step(0);
    model_step(1);
    #1;
    checkDut(0, a_wb, a_code, a_epc, a_bd, a_eret, a_flush, a_stall);
    checkDut(1, b_wb, b_code, b_epc, b_bd, b_eret, b_flush, b_stall);
  end

  task automatic clear_reqs();
    req_valid = 3'b000; req_code = '0; req_pc = '0; req_bd = 3'b000;
    mem_inst_valid = 1'b0; eret_req = 1'b0; int_sig_in = 8'h00;
  endtask

  // Drive one set of requests for a single edge; returns just after that
  // edge so the pulse interval can be checked.
  task automatic applyStimulus(input logic [2:0] rv, input logic [14:0] codes,
                               input logic [95:0] pcs, input logic [2:0] bd,
                               input logic miv, input logic er);
    @(negedge clk);
    req_valid = rv; req_code = codes; req_pc = pcs; req_bd = bd;
    mem_inst_valid = miv; eret_req = er;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    clear_reqs();
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; ie_in = 1'b0; exl_in = 1'b0; int_mask_in = 8'h00; hlt_in = 1'b0;
    clear_reqs();
    #3;
    checkOutput("reset.a_wb",    32'(a_wb),    32'd0);
    checkOutput("reset.a_stall", 32'(a_stall), 32'd0);
    checkOutput("reset.a_epc",   a_epc,        32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // MEM and EX both fault: MEM wins, two flush cycles on instance A.
    applyStimulus(3'b110, {5'h04, 5'h0c, 5'h00}, {32'h00400100, 32'h00400104, 32'h0}, 3'b000, 1'b0, 1'b0);
    checkOutput("mem_win.ex_wb",   32'(a_wb),    32'd1);
    checkOutput("mem_win.ex_code", 32'(a_code),  32'h04);
    checkOutput("mem_win.epc",     a_epc,        32'h00400100);
    checkOutput("mem_win.flush0",  32'(a_flush), 32'd1);
    idle(1);
    checkOutput("mem_win.wb_gone", 32'(a_wb),    32'd0);
    checkOutput("mem_win.flush1",  32'(a_flush), 32'd1);
    idle(1);
    checkOutput("mem_win.flush2",  32'(a_flush), 32'd0);
    checkOutput("mem_win.b_flush2", 32'(b_flush), 32'd1);
    idle(3);

    // Interrupt attached to the MEM instruction, in a delay slot.
    ie_in = 1'b1; exl_in = 1'b0; int_mask_in = 8'hFF; int_sig_in = 8'h04;
    applyStimulus(3'b000, 15'h0, {32'h00400200, 64'h0}, 3'b100, 1'b1, 1'b0);
    checkOutput("int.ex_wb",   32'(a_wb),   32'd1);
    checkOutput("int.ex_code", 32'(a_code), 32'h00);
    checkOutput("int.epc",     a_epc,       32'h00400200);
    checkOutput("int.bd",      32'(a_bd),   32'd1);
    idle(4);

    // Interrupt pending with no instruction in MEM: nothing taken.
    int_sig_in = 8'h04;
    applyStimulus(3'b000, 15'h0, 96'h0, 3'b000, 1'b0, 1'b0);
    checkOutput("int_noinst.ex_wb", 32'(a_wb),    32'd0);
    checkOutput("int_noinst.stall", 32'(a_stall), 32'd0);
    idle(1);

    // ID exception outranks a pending interrupt.
    int_sig_in = 8'h04;
    applyStimulus(3'b001, {10'h0, 5'h0a}, {32'h00400404, 32'h0, 32'h00400400}, 3'b000, 1'b1, 1'b0);
    checkOutput("id_vs_int.ex_code", 32'(a_code), 32'h0a);
    checkOutput("id_vs_int.epc",     a_epc,       32'h00400400);
    idle(4);

    // Exception together with ERET: the exception alone is taken.
    applyStimulus(3'b001, {10'h0, 5'h08}, {64'h0, 32'h00400300}, 3'b000, 1'b0, 1'b1);
    checkOutput("exc_eret.ex_wb",   32'(a_wb),   32'd1);
    checkOutput("exc_eret.ex_code", 32'(a_code), 32'h08);
    checkOutput("exc_eret.eret",    32'(a_eret), 32'd0);
    idle(4);

    // Plain ERET.
    applyStimulus(3'b000, 15'h0, 96'h0, 3'b000, 1'b1, 1'b1);
    checkOutput("eret.pulse", 32'(a_eret),  32'd1);
    checkOutput("eret.ex_wb", 32'(a_wb),    32'd0);
    checkOutput("eret.flush", 32'(a_flush), 32'd1);
    idle(1);
    checkOutput("eret.pulse_gone", 32'(a_eret), 32'd0);
    idle(4);

    // HLT, requests ignored while halted, then interrupt resume.
    hlt_in = 1'b1;
    applyStimulus(3'b100, {5'h01, 10'h0}, {32'h00400500, 64'h0}, 3'b000, 1'b0, 1'b0);
    checkOutput("hlt.ex_code", 32'(a_code), 32'h01);
    idle(2);
    checkOutput("hlt.stall", 32'(a_stall), 32'd1);
    checkOutput("hlt.flush", 32'(a_flush), 32'd0);
    idle(4);
    applyStimulus(3'b111, {5'h04, 5'h05, 5'h08}, {32'h1, 32'h2, 32'h3}, 3'b111, 1'b1, 1'b1);
    checkOutput("halt_ignore.a_wb",   32'(a_wb),   32'd0);
    checkOutput("halt_ignore.b_eret", 32'(b_eret), 32'd0);
    checkOutput("halt_ignore.stall",  32'(a_stall), 32'd1);
    idle(2);
    int_mask_in = 8'hFF; int_sig_in = 8'h08;
    applyStimulus(3'b000, 15'h0, 96'h0, 3'b000, 1'b0, 1'b0);
    checkOutput("resume.ex_wb",   32'(a_wb),   32'd1);
    checkOutput("resume.ex_code", 32'(a_code), 32'h02);
    checkOutput("resume.epc",     a_epc,       32'h0);
    checkOutput("resume.b_code",  32'(b_code), 32'h02);
    idle(1);
    checkOutput("resume.flush1", 32'(a_flush), 32'd1);
    idle(1);
    checkOutput("resume.run_stall", 32'(a_stall), 32'd0);
    idle(4);

    // HLT then external clear: a single low cycle is not enough.
    applyStimulus(3'b100, {5'h01, 10'h0}, {32'h00400510, 64'h0}, 3'b000, 1'b0, 1'b0);
    idle(5);
    hlt_in = 1'b0;
    idle(1);
    hlt_in = 1'b1;
    idle(1);
    checkOutput("clear.short_low", 32'(a_stall), 32'd1);
    hlt_in = 1'b0;
    idle(1);
    checkOutput("clear.one_low", 32'(a_stall), 32'd1);
    idle(1);
    checkOutput("clear.run",   32'(a_stall), 32'd0);
    checkOutput("clear.no_wb", 32'(a_wb),    32'd0);
    idle(3);

    // Longer flush on instance B drops requests that arrive meanwhile.
    applyStimulus(3'b010, {5'h00, 5'h0c, 5'h00}, {32'h0, 32'h00400600, 32'h0}, 3'b000, 1'b0, 1'b0);
    checkOutput("drop.b_code", 32'(b_code), 32'h0c);
    @(negedge clk);
    req_valid = 3'b001; req_code = {10'h0, 5'h09}; req_pc = {64'h0, 32'h00400700};
    @(posedge clk); #1;
    checkOutput("drop.b_wb1",    32'(b_wb),    32'd0);
    checkOutput("drop.b_flush1", 32'(b_flush), 32'd1);
    @(posedge clk); #1;
    checkOutput("drop.b_wb2",    32'(b_wb),    32'd0);
    checkOutput("drop.a_wb2",    32'(a_wb),    32'd0);
    idle(1);
    checkOutput("drop.b_flush3", 32'(b_flush), 32'd0);
    checkOutput("drop.b_wb3",    32'(b_wb),    32'd0);
    idle(4);

    // Reset in the middle of a take.
    applyStimulus(3'b100, {5'h05, 10'h0}, {32'h00400800, 64'h0}, 3'b000, 1'b0, 1'b0);
    checkOutput("rst_mid.ex_wb", 32'(a_wb), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    clear_reqs();
    #1;
    checkOutput("rst_mid.a_flush", 32'(a_flush), 32'd0);
    checkOutput("rst_mid.a_stall", 32'(a_stall), 32'd0);
    checkOutput("rst_mid.a_code",  32'(a_code),  32'h0);
    checkOutput("rst_mid.b_flush", 32'(b_flush), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(4);
    checkOutput("rst_after.a_wb",    32'(a_wb),    32'd0);
    checkOutput("rst_after.b_flush", 32'(b_flush), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
